rename_ckpt: RTL and testbench

Next-generation rename stage for the out-of-order backend. It renames a group of up to DISPATCH_WIDTH decoded uops per cycle onto ROB tags through a speculative busy/tag map, and takes a map snapshot for every branch. A misprediction restores the map in one cycle, with no walk-back. It accepts the in-order prefix of a group that fits the ROB free space and the free checkpoint slots, so it sits between decode and ROB/issue dispatch.

---
 rtl/rename_ckpt.sv | 220 ++++++++++++++++++++++
 tb/tb_rename_ckpt.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_ckpt.sv
// rtl/rename_ckpt.sv - rename stage with busy/tag map and single-cycle branch checkpoint restore
module rename_ckpt #(
  parameter int DISPATCH_WIDTH = 4,
  parameter int COMMIT_WIDTH   = 4,
  parameter int ROB_DEPTH      = 64,
  parameter int ROB_IDX_WIDTH  = $clog2(ROB_DEPTH),
  parameter int NUM_CKPT       = 4,
  parameter int CKPT_IDX_WIDTH = $clog2(NUM_CKPT)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [DISPATCH_WIDTH-1:0]                dec_valid_i,
  input  logic [DISPATCH_WIDTH*5-1:0]              dec_rs1_i,
  input  logic [DISPATCH_WIDTH*5-1:0]              dec_rs2_i,
  input  logic [DISPATCH_WIDTH*5-1:0]              dec_rd_i,
  input  logic [DISPATCH_WIDTH-1:0]                dec_has_rs1_i,
  input  logic [DISPATCH_WIDTH-1:0]                dec_has_rs2_i,
  input  logic [DISPATCH_WIDTH-1:0]                dec_has_rd_i,
  input  logic [DISPATCH_WIDTH-1:0]                dec_is_branch_i,
  input  logic [ROB_IDX_WIDTH-1:0]                 rob_tail_ptr_i,
  input  logic [ROB_IDX_WIDTH:0]                   rob_free_cnt_i,
  output logic [DISPATCH_WIDTH-1:0]                accept_o,
  output logic [DISPATCH_WIDTH-1:0]                rs1_in_rob_o,
  output logic [DISPATCH_WIDTH-1:0]                rs2_in_rob_o,
  output logic [DISPATCH_WIDTH*ROB_IDX_WIDTH-1:0]  rs1_tag_o,
  output logic [DISPATCH_WIDTH*ROB_IDX_WIDTH-1:0]  rs2_tag_o,
  output logic [DISPATCH_WIDTH*ROB_IDX_WIDTH-1:0]  rd_tag_o,
  output logic [DISPATCH_WIDTH*CKPT_IDX_WIDTH-1:0] ckpt_id_o,
  output logic [CKPT_IDX_WIDTH:0]                  ckpt_free_cnt_o,
  input  logic                                     br_resolve_valid_i,
  input  logic [CKPT_IDX_WIDTH-1:0]                br_resolve_ckpt_i,
  input  logic                                     br_mispredict_i,
  input  logic [COMMIT_WIDTH-1:0]                  commit_valid_i,
  input  logic [COMMIT_WIDTH*5-1:0]                commit_areg_i,
  input  logic [COMMIT_WIDTH*ROB_IDX_WIDTH-1:0]    commit_rob_idx_i,
  input  logic                                     flush_i
);

  localparam int DW = DISPATCH_WIDTH;
  localparam int TW = ROB_IDX_WIDTH;
  localparam int KW = CKPT_IDX_WIDTH;
  localparam int NR = 32;

  // live map and snapshots
  logic          map_busy_q  [NR];
  logic [TW-1:0] map_tag_q   [NR];
  logic          snap_busy_q [NUM_CKPT][NR];
  logic [TW-1:0] snap_tag_q  [NUM_CKPT][NR];
  logic [KW-1:0] head_q, tail_q;
  logic [KW:0]   free_q;
  logic [NUM_CKPT-1:0] resolved_q;

  // rename working signals
  logic [DW-1:0] acc, acc_br;
  logic [KW:0]   n_alloc;
  logic [KW-1:0] lane_slot [DW];
  logic [TW-1:0] lane_tag  [DW];
  logic          prev_ok, lane_ok;
  int            br_cnt;
  logic          mispredict, pop;

  logic          run_busy  [NR];
  logic [TW-1:0] run_tag   [NR];
  logic          lane_busy [DW][NR];
  logic [TW-1:0] lane_tags [DW][NR];
  logic          snap_nb   [NUM_CKPT][NR];

  logic [4:0]    r1, r2;

  assign mispredict      = br_resolve_valid_i & br_mispredict_i;
  assign pop             = (free_q != (KW+1)'(NUM_CKPT)) && resolved_q[head_q];
  assign ckpt_free_cnt_o = free_q;
  assign accept_o        = acc;

  // true when a valid commit port retires tag for areg r
  function automatic logic commit_hit(input logic [4:0] r, input logic [TW-1:0] tag);
    commit_hit = 1'b0;
    for (int c = 0; c < COMMIT_WIDTH; c++)
      if (commit_valid_i[c] && commit_areg_i[c*5 +: 5] == r && commit_rob_idx_i[c*TW +: TW] == tag)
        commit_hit = 1'b1;
  endfunction

  // in-order acceptance against ROB space and free checkpoints; tag and slot assignment
  always_comb begin
    acc       = '0;
    acc_br    = '0;
    n_alloc   = '0;
    ckpt_id_o = '0;
    rd_tag_o  = '0;
    prev_ok   = 1'b1;
    lane_ok   = 1'b0;
    br_cnt    = 0;
    for (int i = 0; i < DW; i++) begin
      lane_slot[i] = tail_q + KW'(br_cnt);
      lane_tag[i]  = rob_tail_ptr_i + TW'(i);
      rd_tag_o[i*TW +: TW] = lane_tag[i];
      if (dec_valid_i[i] && dec_is_branch_i[i]) br_cnt = br_cnt + 1;
      lane_ok = prev_ok && dec_valid_i[i] && !flush_i && !mispredict &&
                (i < int'(rob_free_cnt_i)) && (br_cnt <= int'(free_q));
      acc[i]  = lane_ok;
      prev_ok = lane_ok;
      if (lane_ok && dec_is_branch_i[i]) begin
        acc_br[i] = 1'b1;
        ckpt_id_o[i*KW +: KW] = lane_slot[i];
        n_alloc = n_alloc + (KW+1)'(1);
      end
    end
  end

  // source lookup: live map, overridden by the youngest older accepted writer
  always_comb begin
    rs1_in_rob_o = '0;
    rs2_in_rob_o = '0;
    rs1_tag_o    = '0;
    rs2_tag_o    = '0;
    r1 = '0;
    r2 = '0;
    for (int i = 0; i < DW; i++) begin
      r1 = dec_rs1_i[i*5 +: 5];
      r2 = dec_rs2_i[i*5 +: 5];
      if (dec_has_rs1_i[i] && r1 != 5'd0) begin
        rs1_in_rob_o[i]      = map_busy_q[r1];
        rs1_tag_o[i*TW +: TW] = map_tag_q[r1];
        for (int j = 0; j < i; j++)
          if (acc[j] && dec_has_rd_i[j] && dec_rd_i[j*5 +: 5] == r1) begin
            rs1_in_rob_o[i]      = 1'b1;
            rs1_tag_o[i*TW +: TW] = lane_tag[j];
          end
      end
      if (dec_has_rs2_i[i] && r2 != 5'd0) begin
        rs2_in_rob_o[i]      = map_busy_q[r2];
        rs2_tag_o[i*TW +: TW] = map_tag_q[r2];
        for (int j = 0; j < i; j++)
          if (acc[j] && dec_has_rd_i[j] && dec_rd_i[j*5 +: 5] == r2) begin
            rs2_in_rob_o[i]      = 1'b1;
            rs2_tag_o[i*TW +: TW] = lane_tag[j];
          end
      end
    end
  end

  // next map: commit clears first, then dispatch writes on top; per-lane images feed snapshots
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      run_busy[r] = (r != 0) && map_busy_q[r] && !commit_hit(5'(r), map_tag_q[r]);
      run_tag[r]  = map_tag_q[r];
    end
    for (int i = 0; i < DW; i++) begin
      if (acc[i] && dec_has_rd_i[i] && dec_rd_i[i*5 +: 5] != 5'd0) begin
        run_busy[dec_rd_i[i*5 +: 5]] = 1'b1;
        run_tag[dec_rd_i[i*5 +: 5]]  = lane_tag[i];
      end
      lane_busy[i] = run_busy;
      lane_tags[i] = run_tag;
    end
    for (int k = 0; k < NUM_CKPT; k++)
      for (int r = 0; r < NR; r++)
        snap_nb[k][r] = snap_busy_q[k][r] && !commit_hit(5'(r), snap_tag_q[k][r]);
  end

  // state update: flush > mispredict restore > commit/dispatch/resolve
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NR; r++) begin
        map_busy_q[r] <= 1'b0;
        map_tag_q[r]  <= '0;
      end
      for (int k = 0; k < NUM_CKPT; k++)
        for (int r = 0; r < NR; r++) begin
          snap_busy_q[k][r] <= 1'b0;
          snap_tag_q[k][r]  <= '0;
        end
      head_q     <= '0;
      tail_q     <= '0;
      free_q     <= (KW+1)'(NUM_CKPT);
      resolved_q <= '0;
    end else if (flush_i) begin
      for (int r = 0; r < NR; r++) map_busy_q[r] <= 1'b0;
      for (int k = 0; k < NUM_CKPT; k++)
        for (int r = 0; r < NR; r++) snap_busy_q[k][r] <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      free_q     <= (KW+1)'(NUM_CKPT);
      resolved_q <= '0;
    end else if (mispredict) begin
      for (int r = 0; r < NR; r++) begin
        map_busy_q[r] <= snap_nb[br_resolve_ckpt_i][r];
        map_tag_q[r]  <= snap_tag_q[br_resolve_ckpt_i][r];
      end
      for (int k = 0; k < NUM_CKPT; k++)
        for (int r = 0; r < NR; r++) snap_busy_q[k][r] <= snap_nb[k][r];
      tail_q <= br_resolve_ckpt_i + KW'(1);
      free_q <= (KW+1)'(NUM_CKPT) - ({1'b0, br_resolve_ckpt_i - head_q} + (KW+1)'(1));
      resolved_q[br_resolve_ckpt_i] <= 1'b1;
    end else begin
      for (int r = 0; r < NR; r++) begin
        map_busy_q[r] <= run_busy[r];
        map_tag_q[r]  <= run_tag[r];
      end
      for (int k = 0; k < NUM_CKPT; k++)
        for (int r = 0; r < NR; r++) snap_busy_q[k][r] <= snap_nb[k][r];
      if (br_resolve_valid_i) resolved_q[br_resolve_ckpt_i] <= 1'b1;
      if (pop) begin
        resolved_q[head_q] <= 1'b0;
        head_q <= head_q + KW'(1);
      end
      for (int i = 0; i < DW; i++)
        if (acc_br[i]) begin
          resolved_q[lane_slot[i]] <= 1'b0;
          for (int r = 0; r < NR; r++) begin
            snap_busy_q[lane_slot[i]][r] <= lane_busy[i][r];
            snap_tag_q[lane_slot[i]][r]  <= lane_tags[i][r];
          end
        end
      tail_q <= tail_q + KW'(n_alloc);
      free_q <= free_q - n_alloc + (KW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_rename_ckpt.sv
// tb/tb_rename_ckpt.sv - directed self-checking bench for rename_ckpt
module tb_rename_ckpt;

  localparam int DW = 4;
  localparam int CW = 4;
  localparam int TW = 6;
  localparam int KW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [DW-1:0]    dec_valid, dec_has_rs1, dec_has_rs2, dec_has_rd, dec_is_branch;
  logic [DW*5-1:0]  dec_rs1, dec_rs2, dec_rd;
  logic [TW-1:0]    rob_tail;
  logic [TW:0]      rob_free;
  logic [DW-1:0]    accept, rs1_in_rob, rs2_in_rob;
  logic [DW*TW-1:0] rs1_tag, rs2_tag, rd_tag;
  logic [DW*KW-1:0] ckpt_id;
  logic [KW:0]      ckpt_free;
  logic             br_valid, br_mis, flush;
  logic [KW-1:0]    br_ckpt;
  logic [CW-1:0]    commit_valid;
  logic [CW*5-1:0]  commit_areg;
  logic [CW*TW-1:0] commit_idx;

  int checks   = 0;
  int failures = 0;
  logic       pb;
  logic [5:0] pt;

  always #5 clk = ~clk;

  rename_ckpt dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dec_valid_i(dec_valid), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2), .dec_rd_i(dec_rd),
    .dec_has_rs1_i(dec_has_rs1), .dec_has_rs2_i(dec_has_rs2), .dec_has_rd_i(dec_has_rd),
    .dec_is_branch_i(dec_is_branch), .rob_tail_ptr_i(rob_tail), .rob_free_cnt_i(rob_free),
    .accept_o(accept), .rs1_in_rob_o(rs1_in_rob), .rs2_in_rob_o(rs2_in_rob),
    .rs1_tag_o(rs1_tag), .rs2_tag_o(rs2_tag), .rd_tag_o(rd_tag),
    .ckpt_id_o(ckpt_id), .ckpt_free_cnt_o(ckpt_free),
    .br_resolve_valid_i(br_valid), .br_resolve_ckpt_i(br_ckpt), .br_mispredict_i(br_mis),
    .commit_valid_i(commit_valid), .commit_areg_i(commit_areg), .commit_rob_idx_i(commit_idx),
    .flush_i(flush)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    dec_valid = '0; dec_has_rs1 = '0; dec_has_rs2 = '0; dec_has_rd = '0; dec_is_branch = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    rob_tail = '0; rob_free = 7'd64;
    br_valid = 1'b0; br_mis = 1'b0; br_ckpt = '0; flush = 1'b0;
    commit_valid = '0; commit_areg = '0; commit_idx = '0;
  endtask

  task automatic lane(input int i, input logic [4:0] rs1, input logic hrs1,
                      input logic [4:0] rd, input logic hrd, input logic br);
    dec_valid[i] = 1'b1;
    dec_rs1[i*5 +: 5] = rs1; dec_has_rs1[i] = hrs1;
    dec_rd[i*5 +: 5]  = rd;  dec_has_rd[i]  = hrd;
    dec_is_branch[i]  = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reads the live mapping of r through a harmless lane-0 read, then advances a cycle
  task automatic probe(input logic [4:0] r, output logic b, output logic [5:0] t);
    clr();
    lane(0, r, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    b = rs1_in_rob[0];
    t = rs1_tag[5:0];
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clr();
    #12 rst_n = 1'b1;
    check_eq("reset_free", 32'(ckpt_free), 4);
    probe(5'd5, pb, pt);
    check_eq("reset_x5_busy", 32'(pb), 0);

    // intra-group dependency with tag wrap
    clr(); rob_tail = 6'd62;
    lane(0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    lane(1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    lane(2, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    lane(3, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    dec_has_rs2[1] = 1'b1; dec_rs2[9:5] = 5'd0;
    dec_has_rs2[2] = 1'b1; dec_rs2[14:10] = 5'd5;
    #1;
    check_eq("dep_accept", 32'(accept), 4'hf);
    check_eq("dep_rd_tags", 32'(rd_tag), 266238);
    check_eq("dep_l1_rs1_busy", 32'(rs1_in_rob[1]), 1);
    check_eq("dep_l1_rs1_tag", 32'(rs1_tag[11:6]), 62);
    check_eq("dep_l3_rs1_tag", 32'(rs1_tag[23:18]), 0);
    check_eq("dep_l3_rs1_busy", 32'(rs1_in_rob[3]), 1);
    check_eq("dep_l1_rs2_x0", 32'(rs2_in_rob[1]), 0);
    check_eq("dep_l2_rs2_tag", 32'(rs2_tag[17:12]), 62);
    tick();
    probe(5'd5, pb, pt);
    check_eq("dep_x5_busy", 32'(pb), 1);
    check_eq("dep_x5_tag", 32'(pt), 0);

    // ROB backpressure
    clr(); rob_free = 7'd2;
    lane(0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    lane(1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    lane(2, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    lane(3, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    #1;
    check_eq("robbp_accept", 32'(accept), 4'h3);
    tick();
    probe(5'd12, pb, pt);
    check_eq("robbp_x12_busy", 32'(pb), 0);
    probe(5'd11, pb, pt);
    check_eq("robbp_x11_busy", 32'(pb), 1);
    check_eq("robbp_x11_tag", 32'(pt), 1);
    clr(); rob_free = 7'd0;
    lane(0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
    #1;
    check_eq("robzero_accept", 32'(accept), 0);
    tick();

    // checkpoint exhaustion
    clr();
    lane(0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    lane(1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    lane(2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    check_eq("ck3_accept", 32'(accept), 4'h7);
    check_eq("ck3_ids", 32'(ckpt_id), 36);
    tick();
    check_eq("ck3_free", 32'(ckpt_free), 1);
    clr();
    lane(0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    lane(1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    lane(2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    lane(3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    check_eq("ckex_accept", 32'(accept), 4'h7);
    check_eq("ckex_ids", 32'(ckpt_id), 12);
    tick();
    check_eq("ckex_free", 32'(ckpt_free), 0);
    clr();
    lane(0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    check_eq("ck0_br_lane0", 32'(accept), 0);
    clr();
    lane(0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    lane(1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    check_eq("ck0_br_lane1", 32'(accept), 4'h1);
    tick();
    clr(); flush = 1'b1;
    tick();
    clr();
    check_eq("flush_free", 32'(ckpt_free), 4);
    probe(5'd5, pb, pt);
    check_eq("flush_x5_busy", 32'(pb), 0);

    // mispredict restore and commit into a snapshot
    clr(); rob_tail = 6'd20;
    lane(0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    lane(1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    lane(2, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    #1;
    check_eq("mpA_accept", 32'(accept), 4'h7);
    tick();
    clr(); rob_tail = 6'd10;
    lane(0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    lane(1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    lane(2, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    lane(3, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    #1;
    check_eq("mpB_accept", 32'(accept), 4'hf);
    check_eq("mpB_ids", 32'(ckpt_id), 200);
    tick();
    check_eq("mpB_free", 32'(ckpt_free), 0);
    probe(5'd7, pb, pt);
    check_eq("mpB_x7_tag", 32'(pt), 13);
    clr();
    commit_valid = 4'b0011;
    commit_areg[4:0] = 5'd3; commit_idx[5:0]  = 6'd10;
    commit_areg[9:5] = 5'd7; commit_idx[11:6] = 6'd12;
    tick();
    probe(5'd3, pb, pt);
    check_eq("commit_x3_live", 32'(pb), 0);
    clr(); br_valid = 1'b1; br_mis = 1'b1; br_ckpt = 2'd2;
    lane(0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    #1;
    check_eq("mp_cycle_accept", 32'(accept), 0);
    tick();
    check_eq("mp_free", 32'(ckpt_free), 1);
    probe(5'd7, pb, pt);
    check_eq("mp_x7_busy", 32'(pb), 1);
    check_eq("mp_x7_tag", 32'(pt), 22);
    probe(5'd3, pb, pt);
    check_eq("mp_x3_busy", 32'(pb), 0);
    probe(5'd9, pb, pt);
    check_eq("mp_x9_busy", 32'(pb), 0);

    // correct resolution, head pops, net count change and pointer wrap
    clr(); br_valid = 1'b1; br_ckpt = 2'd0;
    tick();
    clr(); br_valid = 1'b1; br_ckpt = 2'd1;
    tick();
    check_eq("pop0_free", 32'(ckpt_free), 2);
    clr();
    lane(0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    check_eq("alloc_pop_id", 32'(ckpt_id), 3);
    tick();
    check_eq("alloc_pop_free", 32'(ckpt_free), 2);
    clr();
    tick();
    check_eq("pop_mp_slot_free", 32'(ckpt_free), 3);
    tick();
    check_eq("no_pop_free", 32'(ckpt_free), 3);
    clr();
    lane(0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    lane(1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    check_eq("wrap_ids", 32'(ckpt_id), 4);
    tick();
    check_eq("wrap_free", 32'(ckpt_free), 1);

    // flush together with mispredict and commit
    clr(); flush = 1'b1; br_valid = 1'b1; br_mis = 1'b1; br_ckpt = 2'd3;
    commit_valid = 4'b0001; commit_areg[4:0] = 5'd7; commit_idx[5:0] = 6'd22;
    lane(0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    #1;
    check_eq("fl_mp_accept", 32'(accept), 0);
    tick();
    clr();
    check_eq("fl_mp_free", 32'(ckpt_free), 4);
    probe(5'd7, pb, pt);
    check_eq("fl_mp_x7_busy", 32'(pb), 0);

    // asynchronous reset in the middle of a group
    clr(); rob_tail = 6'd40;
    lane(0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    check_eq("pre_rst_free", 32'(ckpt_free), 3);
    probe(5'd9, pb, pt);
    check_eq("pre_rst_x9_tag", 32'(pt), 40);
    clr();
    lane(0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
    lane(1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_free", 32'(ckpt_free), 4);
    #2;
    rst_n = 1'b1;
    probe(5'd9, pb, pt);
    check_eq("rst_x9_busy", 32'(pb), 0);
    probe(5'd11, pb, pt);
    check_eq("rst_x11_busy", 32'(pb), 0);
    check_eq("rst_free_after", 32'(ckpt_free), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
